// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU with single-cycle ops and bit-serial variable shifts.
module alu_iterative #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [5:0]        i_aluControl,
  input  logic [DATA_W-1:0] i_op1,
  input  logic [DATA_W-1:0] i_op2,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_overflow,
  output logic              o_illegal
);
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_LUI  = 6'b111100;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]          kind_q, kind_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                ovf_q, ovf_d;
  logic                ill_q, ill_d;

  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   sum, dif, alu_res, step;
  logic                add_ovf, sub_ovf, alu_ovf, alu_ill, is_shift, accept, iterate;

  assign shamt    = i_op1[SHAMT_W-1:0];
  assign sum      = i_op1 + i_op2;
  assign dif      = i_op1 - i_op2;
  assign add_ovf  = (i_op1[DATA_W-1] == i_op2[DATA_W-1]) && (sum[DATA_W-1] != i_op1[DATA_W-1]);
  assign sub_ovf  = (i_op1[DATA_W-1] != i_op2[DATA_W-1]) && (dif[DATA_W-1] != i_op1[DATA_W-1]);
  assign is_shift = (i_aluControl == F_SLLV) || (i_aluControl == F_SRLV) || (i_aluControl == F_SRAV);
  assign accept   = (state_q == IDLE) && i_start;
  assign iterate  = is_shift && (shamt != '0);

  // kind_q holds funct[1:0]: 00 = left, 10 = logical right, 11 = arithmetic right
  assign step = (kind_q == 2'b00) ? {acc_q[DATA_W-2:0], 1'b0}
                                  : {kind_q[0] & acc_q[DATA_W-1], acc_q[DATA_W-1:1]};

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (i_aluControl)
      F_ADD:  begin alu_res = sum; alu_ovf = add_ovf; end
      F_ADDU: alu_res = sum;
      F_SUB:  begin alu_res = dif; alu_ovf = sub_ovf; end
      F_SUBU: alu_res = dif;
      F_AND:  alu_res = i_op1 & i_op2;
      F_OR:   alu_res = i_op1 | i_op2;
      F_XOR:  alu_res = i_op1 ^ i_op2;
      F_NOR:  alu_res = ~(i_op1 | i_op2);
      F_SLT:  alu_res = {{(DATA_W-1){1'b0}}, $signed(i_op1) < $signed(i_op2)};
      F_SLTU: alu_res = {{(DATA_W-1){1'b0}}, i_op1 < i_op2};
      F_LUI:  alu_res = {i_op2[15:0], {(DATA_W-16){1'b0}}};
      F_SLLV, F_SRLV, F_SRAV: alu_res = i_op2;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      kind_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      kind_q   <= kind_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (iterate ? SHIFT : DONE) : IDLE;
      SHIFT:   state_d = (cnt_q == SHAMT_W'(1)) ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    if (accept) begin
      acc_d  = i_op2;
      cnt_d  = shamt;
      kind_d = i_aluControl[1:0];
      if (!iterate) begin
        result_d = alu_res;
        ovf_d    = alu_ovf;
        ill_d    = alu_ill;
      end
    end else if (state_q == SHIFT) begin
      acc_d = step;
      cnt_d = cnt_q - SHAMT_W'(1);
      if (cnt_q == SHAMT_W'(1)) begin
        result_d = step;
        ovf_d    = 1'b0;
        ill_d    = 1'b0;
      end
    end
    zero_d = (result_d == '0);
  end

  always_comb begin
    o_busy     = state_q != IDLE;
    o_done     = state_q == DONE;
    o_result   = result_q;
    o_zero     = zero_q;
    o_overflow = ovf_q;
    o_illegal  = ill_q;
  end
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed and randomized checks of alu_iterative against a behavioural model.
module tb_alu_iterative;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [5:0]  i_aluControl = '0;
  logic [31:0] i_op1 = '0;
  logic [31:0] i_op2 = '0;
  logic        o_busy, o_done, o_zero, o_overflow, o_illegal;
  logic [31:0] o_result;
  int          n_chk = 0;
  int          n_fail = 0;

  alu_iterative #(.DATA_W(32), .SHAMT_W(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_aluControl(i_aluControl),
    .i_op1(i_op1), .i_op2(i_op2), .o_busy(o_busy), .o_done(o_done), .o_result(o_result),
    .o_zero(o_zero), .o_overflow(o_overflow), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] a, b, r;
    logic        ov, il;
    int          lat;
  } vec_t;

  function automatic void model(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic il, output int lat);
    longint s;
    int n;
    n = int'(a[4:0]);
    ov = 1'b0; il = 1'b0; lat = 1; r = '0;
    case (c)
      6'h20: begin s = longint'($signed(a)) + longint'($signed(b)); r = a + b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'h21: r = a + b;
      6'h22: begin s = longint'($signed(a)) - longint'($signed(b)); r = a - b; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'h23: r = a - b;
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: r = (a < b) ? 32'd1 : 32'd0;
      6'h3C: r = b << 16;
      6'h04: begin r = b << n; lat = (n == 0) ? 1 : n + 1; end
      6'h06: begin r = b >> n; lat = (n == 0) ? 1 : n + 1; end
      6'h07: begin r = 32'($signed(b) >>> n); lat = (n == 0) ? 1 : n + 1; end
      default: il = 1'b1;
    endcase
  endfunction

  // Starts one op in the cycle after the call and waits (bounded) for o_done.
  task automatic run_op(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b, input bit hold,
                        output logic [31:0] r, output logic z, output logic ov, output logic il,
                        output int lat, output bit idle_ok, output bit busy_ok);
    @(posedge i_clk); #1;
    idle_ok = !o_busy && !o_done;
    i_start = 1'b1; i_aluControl = c; i_op1 = a; i_op2 = b;
    busy_ok = 1'b1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk); #1;
      if (!o_busy) busy_ok = 1'b0;
      if (o_done) begin lat = k; break; end
      i_start = hold;
      i_aluControl = hold ? 6'h20 : 6'($urandom);
      i_op1 = $urandom; i_op2 = $urandom;
    end
    i_start = 1'b0;
    r = o_result; z = o_zero; ov = o_overflow; il = o_illegal;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    n_chk++;
    if ({o_busy, o_done, o_result, o_zero, o_overflow, o_illegal} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b result=%h zero=%b ovf=%b ill=%b, required 0 0 00000000 1 0 0",
               o_busy, o_done, o_result, o_zero, o_overflow, o_illegal);
    end
  endtask

  task automatic test_directed;
    vec_t v[12];
    logic [31:0] r;
    logic z, ov, il;
    int lat;
    bit idle_ok, busy_ok;
    v[0]  = '{6'h20, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b1, 1'b0, 1};
    v[1]  = '{6'h21, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0, 1};
    v[2]  = '{6'h22, 32'h5, 32'h5, 32'h0, 1'b0, 1'b0, 1};
    v[3]  = '{6'h2A, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1};
    v[4]  = '{6'h2B, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1};
    v[5]  = '{6'h07, 32'h4, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 5};
    v[6]  = '{6'h06, 32'h4, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 5};
    v[7]  = '{6'h04, 32'h0, 32'h1234, 32'h1234, 1'b0, 1'b0, 1};
    v[8]  = '{6'h00, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 1};
    v[9]  = '{6'h3C, 32'h0, 32'hFFFFABCD, 32'hABCD0000, 1'b0, 1'b0, 1};
    v[10] = '{6'h22, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b0, 1};
    v[11] = '{6'h27, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 1'b0, 1'b0, 1};
    foreach (v[i]) begin
      run_op(v[i].c, v[i].a, v[i].b, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
      n_chk++;
      if ({lat, r, z, ov, il, busy_ok} !== {v[i].lat, v[i].r, v[i].r == 32'h0, v[i].ov, v[i].il, 1'b1}) begin
        n_fail++;
        $display("FAIL directed[%0d] code=%h: lat=%0d result=%h zero=%b ovf=%b ill=%b busy_ok=%b, required lat=%0d result=%h ovf=%b ill=%b",
                 i, v[i].c, lat, r, z, ov, il, busy_ok, v[i].lat, v[i].r, v[i].ov, v[i].il);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [31:0] r;
    logic z, ov, il;
    int lat;
    bit idle_ok, busy_ok;
    run_op(6'h04, 32'd31, 32'h1, 1'b1, r, z, ov, il, lat, idle_ok, busy_ok);
    n_chk++;
    if ({lat, r, busy_ok} !== {32, 32'h80000000, 1'b1}) begin
      n_fail++;
      $display("FAIL ignore_start sllv31: lat=%0d result=%h busy_ok=%b, required lat=32 result=80000000 busy_ok=1",
               lat, r, busy_ok);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] r;
    logic z, ov, il;
    int lat;
    bit idle_ok, busy_ok, saw_done;
    run_op(6'h20, 32'h7FFFFFFF, 32'h1, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_aluControl = 6'h04; i_op1 = 32'd10; i_op2 = 32'hABC;
    saw_done = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (o_done) saw_done = 1'b1;
      if (k < 5) begin
        n_chk++;
        if (o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_reset busy cycle %0d: busy=%b, required 1", k, o_busy);
        end
      end
      i_rst = (k == 4);
    end
    n_chk++;
    if ({saw_done, o_busy, o_result, o_zero, o_overflow, o_illegal} !== {1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset state: saw_done=%b busy=%b result=%h zero=%b ovf=%b ill=%b, required 0 0 00000000 1 0 0",
               saw_done, o_busy, o_result, o_zero, o_overflow, o_illegal);
    end
    run_op(6'h20, 32'd100, 32'd23, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
    n_chk++;
    if ({lat, r, ov, idle_ok} !== {1, 32'd123, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL mid_reset recovery add: lat=%0d result=%h ovf=%b idle=%b, required lat=1 result=0000007b ovf=0 idle=1",
               lat, r, ov, idle_ok);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    logic z, ov, il;
    int lat;
    bit idle_ok, busy_ok;
    run_op(6'h25, 32'hF0, 32'h0F, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
    n_chk++;
    if ({lat, r} !== {1, 32'hFF}) begin
      n_fail++;
      $display("FAIL b2b first: lat=%0d result=%h, required lat=1 result=000000ff", lat, r);
    end
    run_op(6'h26, 32'hFF, 32'hFF, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
    n_chk++;
    if ({lat, r, z, idle_ok} !== {1, 32'h0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b second: lat=%0d result=%h zero=%b idle=%b, required lat=1 result=00000000 zero=1 idle=1",
               lat, r, z, idle_ok);
    end
  endtask

  task automatic test_random;
    logic [5:0] codes[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h3C, 6'h04, 6'h06, 6'h07};
    logic [5:0] c;
    logic [31:0] a, b, r, er;
    logic z, ov, il, eov, eil;
    int lat, elat;
    bit idle_ok, busy_ok;
    for (int i = 0; i < 150; i++) begin
      c = ($urandom_range(7) == 0) ? 6'($urandom) : codes[$urandom_range(13)];
      a = $urandom;
      b = ($urandom_range(3) == 0) ? {1'b0, 31'h7FFFFFFF} ^ 32'($urandom_range(3)) : $urandom;
      model(c, a, b, er, eov, eil, elat);
      run_op(c, a, b, 1'b0, r, z, ov, il, lat, idle_ok, busy_ok);
      n_chk++;
      if ({lat, r, z, ov, il, idle_ok, busy_ok} !== {elat, er, er == 32'h0, eov, eil, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL random[%0d] code=%h a=%h b=%h: lat=%0d result=%h zero=%b ovf=%b ill=%b idle=%b busy_ok=%b, required lat=%0d result=%h ovf=%b ill=%b",
                 i, c, a, b, lat, r, z, ov, il, idle_ok, busy_ok, elat, er, eov, eil);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
